// File: rtl/adder_stim_pkg.sv
// Shared definitions for the adder stimulus/checker block.
//   - default operand and counter widths
//   - Galois LFSR feedback mask (x^32 + x^22 + x^2 + x + 1)
//   - controller state encoding
package adder_stim_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefCntW  = 16;

  localparam logic [31:0] LfsrMask = 32'h8020_0003;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StGo,
    StWait,
    StCheck,
    StDone
  } state_e;

endpackage

// File: rtl/adder_stim_lfsr.sv
// Operand generator: right-shifting Galois LFSR with feedback from bit 0.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (state -> 1)
//   clr_i           synchronous return to the reset state
//   load_i, seed_i  load a seed (a zero seed is replaced by 1)
//   adv2_i          advance the register by two steps
//   state_o         current state
//   next_o          state advanced by one step
module adder_stim_lfsr
  import adder_stim_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] seed_i,
  input  logic             adv2_i,
  output logic [Width-1:0] state_o,
  output logic [Width-1:0] next_o
);

  localparam logic [Width-1:0] Mask = Width'(LfsrMask);
  localparam logic [Width-1:0] One  = Width'(1);

  logic [Width-1:0] state_q, state_d;

  function automatic logic [Width-1:0] step(input logic [Width-1:0] s);
    return (s >> 1) ^ (s[0] ? Mask : '0);
  endfunction

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = One;
    end else if (load_i) begin
      // All-zero is the lock-up state of the LFSR.
      state_d = (seed_i == '0) ? One : seed_i;
    end else if (adv2_i) begin
      state_d = step(step(state_q));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= One;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign next_o  = step(state_q);

endmodule

// File: rtl/adder_stim_checker.sv
// Drives pseudo-random operand pairs into an external adder, waits for its
// result (with a per-vector timeout) and counts vectors and errors.
// Ports:
//   wb_clk_i, wb_rst_n          clock, asynchronous active-low reset
//   active                      block enable; low holds outputs at reset values
//   start                       begin a run (accepted in IDLE/DONE only)
//   cfg_count/seed/timeout      vectors per run, LFSR seed, wait limit
//   a_out, b_out, adder_go      operands and launch pulse to the adder
//   adder_done/sum/carry        adder result strobe and value
//   busy, run_done              run in progress / run finished
//   vec_count, err_count        vectors completed, mismatches + timeouts
//   timeout_seen                sticky per-run timeout flag
module adder_stim_checker
  import adder_stim_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             active,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [7:0]       cfg_timeout,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             adder_go,
  input  logic             adder_done,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_carry,
  output logic             busy,
  output logic             run_done,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             timeout_seen
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] vec_q, vec_d, err_q, err_d;
  logic             tmo_seen_q, tmo_seen_d;
  logic             tmo_q, tmo_d;
  logic [7:0]       timer_q, timer_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic [WIDTH-1:0] lfsr_state, lfsr_next;
  logic             lfsr_load, lfsr_adv2;
  logic [WIDTH:0]   sum_exp;
  logic             mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  adder_stim_lfsr #(
    .Width (WIDTH)
  ) u_lfsr (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_n),
    .clr_i   (!active),
    .load_i  (lfsr_load),
    .seed_i  (cfg_seed),
    .adv2_i  (lfsr_adv2),
    .state_o (lfsr_state),
    .next_o  (lfsr_next)
  );

  assign sum_exp  = {1'b0, a_q} + {1'b0, b_q};
  assign mismatch = tmo_q || (sum_q != sum_exp);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    vec_d      = vec_q;
    err_d      = err_q;
    tmo_seen_d = tmo_seen_q;
    tmo_d      = tmo_q;
    timer_d    = timer_q;
    sum_d      = sum_q;
    lfsr_load  = 1'b0;
    lfsr_adv2  = 1'b0;

    if (!active) begin
      // Deselect overrides everything, including a coincident start.
      state_d    = StIdle;
      a_d        = '0;
      b_d        = '0;
      vec_d      = '0;
      err_d      = '0;
      tmo_seen_d = 1'b0;
      tmo_d      = 1'b0;
      timer_d    = '0;
      sum_d      = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d    = StLoad;
            vec_d      = '0;
            err_d      = '0;
            tmo_seen_d = 1'b0;
            lfsr_load  = 1'b1;
          end
        end
        StLoad: begin
          if (vec_q == cfg_count) begin
            state_d = StDone;
          end else begin
            a_d       = lfsr_state;
            b_d       = lfsr_next;
            lfsr_adv2 = 1'b1;
            state_d   = StGo;
          end
        end
        StGo: begin
          timer_d = '0;
          state_d = StWait;
        end
        StWait: begin
          // A done strobe wins over a coincident timeout.
          if (adder_done) begin
            sum_d   = {adder_carry, adder_sum};
            tmo_d   = 1'b0;
            state_d = StCheck;
          end else if (timer_q == cfg_timeout) begin
            tmo_d      = 1'b1;
            tmo_seen_d = 1'b1;
            state_d    = StCheck;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        StCheck: begin
          if (mismatch) begin
            err_d = sat_inc(err_q);
          end
          vec_d   = sat_inc(vec_q);
          state_d = StLoad;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      vec_q      <= '0;
      err_q      <= '0;
      tmo_seen_q <= 1'b0;
      tmo_q      <= 1'b0;
      timer_q    <= '0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      vec_q      <= vec_d;
      err_q      <= err_d;
      tmo_seen_q <= tmo_seen_d;
      tmo_q      <= tmo_d;
      timer_q    <= timer_d;
      sum_q      <= sum_d;
    end
  end

  // Outputs are gated so deselecting the block takes effect immediately.
  assign a_out        = active ? a_q : '0;
  assign b_out        = active ? b_q : '0;
  assign adder_go     = active && (state_q == StGo);
  assign busy         = active && (state_q != StIdle) && (state_q != StDone);
  assign run_done     = active && (state_q == StDone);
  assign vec_count    = active ? vec_q : '0;
  assign err_count    = active ? err_q : '0;
  assign timeout_seen = active && tmo_seen_q;

endmodule

// File: tb/tb_adder_stim_checker.sv
// Directed bench for adder_stim_checker with a behavioural adder that
// answers two cycles after each launch pulse.
module tb_adder_stim_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        active;
  logic        start;
  logic [15:0] cfg_count;
  logic [31:0] cfg_seed;
  logic [7:0]  cfg_timeout;
  logic [31:0] a_out, b_out, adder_sum;
  logic        adder_go, adder_done, adder_carry;
  logic        busy, run_done, timeout_seen;
  logic [15:0] vec_count, err_count;

  // Adder model controls.
  logic        model_en;
  logic        inject;
  logic [15:0] inject_idx;
  logic        go_d1, go_d2;
  logic [32:0] model_res;

  int n_checks = 0;
  int n_fail   = 0;
  int gos;
  int gap;
  logic [31:0] op_a [2];
  logic [31:0] op_b [2];

  always #5 clk = ~clk;

  adder_stim_checker #(
    .WIDTH (32),
    .CNT_W (16)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_n     (rst_n),
    .active       (active),
    .start        (start),
    .cfg_count    (cfg_count),
    .cfg_seed     (cfg_seed),
    .cfg_timeout  (cfg_timeout),
    .a_out        (a_out),
    .b_out        (b_out),
    .adder_go     (adder_go),
    .adder_done   (adder_done),
    .adder_sum    (adder_sum),
    .adder_carry  (adder_carry),
    .busy         (busy),
    .run_done     (run_done),
    .vec_count    (vec_count),
    .err_count    (err_count),
    .timeout_seen (timeout_seen)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_d1 <= 1'b0;
      go_d2 <= 1'b0;
    end else begin
      go_d1 <= adder_go;
      go_d2 <= go_d1;
    end
  end

  always_comb begin
    model_res = {1'b0, a_out} + {1'b0, b_out};
    if (inject && (vec_count == inject_idx)) model_res[0] = ~model_res[0];
  end
  assign {adder_carry, adder_sum} = model_res;
  assign adder_done = model_en && go_d2;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [15:0] cnt);
    cfg_count = cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples on falling edges until run_done; records launch count, the first
  // two operand pairs and the spacing between the first two launches.
  task automatic wait_run_done(input int max_cyc);
    int first_go;
    gos      = 0;
    gap      = -1;
    first_go = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (adder_go) begin
        if (gos < 2) begin
          op_a[gos] = a_out;
          op_b[gos] = b_out;
        end
        if (gos == 0) first_go = i;
        else if (gos == 1) gap = i - first_go;
        gos++;
      end
      if (run_done) break;
    end
    check_eq("run_done_in_time", 64'(run_done), 64'd1);
  endtask

  task automatic wait_go(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (adder_go) break;
    end
    check_eq("go_in_time", 64'(adder_go), 64'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    active      = 1'b1;
    start       = 1'b0;
    cfg_count   = '0;
    cfg_seed    = 32'd1;
    cfg_timeout = 8'd20;
    model_en    = 1'b1;
    inject      = 1'b0;
    inject_idx  = 16'd1;

    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_a_out", 64'(a_out), 64'd0);
    check_eq("rst_b_out", 64'(b_out), 64'd0);
    check_eq("rst_go", 64'(adder_go), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_run_done", 64'(run_done), 64'd0);
    check_eq("rst_vec", 64'(vec_count), 64'd0);
    check_eq("rst_err", 64'(err_count), 64'd0);
    check_eq("rst_tmo", 64'(timeout_seen), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Four clean vectors, seed 1.
    start_run(16'd4);
    check_eq("run1_busy", 64'(busy), 64'd1);
    wait_run_done(200);
    check_eq("run1_vec", 64'(vec_count), 64'd4);
    check_eq("run1_err", 64'(err_count), 64'd0);
    check_eq("run1_gos", 64'(gos), 64'd4);
    check_eq("run1_busy_end", 64'(busy), 64'd0);
    check_eq("run1_tmo", 64'(timeout_seen), 64'd0);
    check_eq("run1_gap", 64'(gap), 64'd5);
    check_eq("run1_a0", 64'(op_a[0]), 64'h0000_0001);
    check_eq("run1_b0", 64'(op_b[0]), 64'h8020_0003);
    check_eq("run1_a1", 64'(op_a[1]), 64'hC030_0002);
    check_eq("run1_b1", 64'(op_b[1]), 64'h6018_0001);

    // Corrupted sum on the second vector.
    inject = 1'b1;
    start_run(16'd3);
    wait_run_done(200);
    check_eq("run2_vec", 64'(vec_count), 64'd3);
    check_eq("run2_err", 64'(err_count), 64'd1);
    check_eq("run2_tmo", 64'(timeout_seen), 64'd0);
    inject = 1'b0;

    // Adder never answers: every vector times out after six WAIT cycles.
    model_en    = 1'b0;
    cfg_timeout = 8'd5;
    start_run(16'd2);
    wait_run_done(200);
    check_eq("run3_vec", 64'(vec_count), 64'd2);
    check_eq("run3_err", 64'(err_count), 64'd2);
    check_eq("run3_tmo", 64'(timeout_seen), 64'd1);
    check_eq("run3_gap", 64'(gap), 64'd9);
    model_en    = 1'b1;
    cfg_timeout = 8'd20;

    // Empty run: LOAD then DONE, no launch.
    start_run(16'd0);
    check_eq("run4_busy", 64'(busy), 64'd1);
    check_eq("run4_go0", 64'(adder_go), 64'd0);
    @(negedge clk);
    check_eq("run4_done", 64'(run_done), 64'd1);
    check_eq("run4_go1", 64'(adder_go), 64'd0);
    check_eq("run4_vec", 64'(vec_count), 64'd0);
    check_eq("run4_tmo", 64'(timeout_seen), 64'd0);

    // Asynchronous reset during WAIT of the third vector.
    start_run(16'd5);
    repeat (3) wait_go(50);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_vec", 64'(vec_count), 64'd0);
    check_eq("arst_a_out", 64'(a_out), 64'd0);
    check_eq("arst_b_out", 64'(b_out), 64'd0);
    check_eq("arst_go", 64'(adder_go), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("arst_idle_busy", 64'(busy), 64'd0);
    check_eq("arst_idle_done", 64'(run_done), 64'd0);

    // start while busy is ignored; deselect wins over a coincident start.
    start_run(16'd5);
    wait_go(50);
    check_eq("act_a0", 64'(a_out), 64'h0000_0001);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_go(50);
    check_eq("act_a1", 64'(a_out), 64'hC030_0002);
    check_eq("act_vec1", 64'(vec_count), 64'd1);
    active = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    check_eq("act_off_busy", 64'(busy), 64'd0);
    check_eq("act_off_vec", 64'(vec_count), 64'd0);
    check_eq("act_off_a", 64'(a_out), 64'd0);
    check_eq("act_off_go", 64'(adder_go), 64'd0);
    start  = 1'b0;
    active = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("act_on_busy", 64'(busy), 64'd0);
    check_eq("act_on_done", 64'(run_done), 64'd0);
    check_eq("act_on_vec", 64'(vec_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
